// File: rtl/mem_arb.sv
// mem_arb: arbitrates fetch, load and store requesters onto a single
// byte-serial memory controller port, one transaction at a time.
//
// Handshake (requester side): a requester raises *_req with a stable payload
// and holds it until it sees its one-cycle *_done pulse. A request still high
// in the done cycle is taken as a new back-to-back request. The controller
// side sees mc_valid with stable command fields until it returns mc_done;
// mc_valid drops the cycle after mc_done and a command is never withdrawn.
//
// Optional feature macro: ARB_FAIR_EN. When defined, a starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive load/store grants made
// while a fetch was waiting. When undefined, priority is strictly st > ld > if.
//
// state_dbg exposes the FSM state (0 IDLE, 1 BUSY, 2 DISCARD).
module mem_arb #(
  parameter logic [2:0] STARVE_LIMIT = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_len,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_len,
  input  logic [31:0] st_data,
  output logic        if_done,
  output logic        ld_done,
  output logic        st_done,
  output logic [31:0] rdata,
  output logic        mc_valid,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_t;

  state_t state;
  owner_t owner;
  owner_t grant;

  // A flush kills fetch and load traffic for the cycle it is seen in IDLE;
  // stores are architectural and are never dropped.
  logic if_ok;
  logic ld_ok;
  logic st_ok;
  logic force_if;

  assign if_ok = if_req && !clear;
  assign ld_ok = ld_req && !clear;
  assign st_ok = st_req;

`ifdef ARB_FAIR_EN
  logic [2:0] starve_cnt;

  assign force_if = if_ok && (starve_cnt == STARVE_LIMIT);

  // Count load/store grants taken while a fetch waits; saturates at the limit
  // so a flush-blocked fetch cannot wrap the counter past the trigger value.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (rdy) begin
      if (!if_req) begin
        starve_cnt <= 3'd0;
      end else if (state == IDLE) begin
        if (grant == OWN_IF) begin
          starve_cnt <= 3'd0;
        end else if ((grant == OWN_LD || grant == OWN_ST) &&
                     (starve_cnt != STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grant decision for the IDLE state: fairness override, then st > ld > if.
  always_comb begin
    grant = OWN_NONE;
    if (force_if) begin
      grant = OWN_IF;
    end else if (st_ok) begin
      grant = OWN_ST;
    end else if (ld_ok) begin
      grant = OWN_LD;
    end else if (if_ok) begin
      grant = OWN_IF;
    end
  end

  assign state_dbg = state;

  // Arbiter FSM with registered command, completion pulses and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      if_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      rdata    <= 32'd0;
      mc_valid <= 1'b0;
      mc_we    <= 1'b0;
      mc_addr  <= 32'd0;
      mc_len   <= 3'd0;
      mc_wdata <= 32'd0;
    end else if (rdy) begin
      // Done pulses and read data last a single enabled cycle.
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      rdata   <= 32'd0;
      case (state)
        IDLE: begin
          owner <= grant;
          case (grant)
            OWN_IF: begin
              state    <= BUSY;
              mc_valid <= 1'b1;
              mc_we    <= 1'b0;
              mc_addr  <= if_addr;
              mc_len   <= 3'd4;
              mc_wdata <= 32'd0;
            end
            OWN_LD: begin
              state    <= BUSY;
              mc_valid <= 1'b1;
              mc_we    <= 1'b0;
              mc_addr  <= ld_addr;
              mc_len   <= ld_len;
              mc_wdata <= 32'd0;
            end
            OWN_ST: begin
              state    <= BUSY;
              mc_valid <= 1'b1;
              mc_we    <= 1'b1;
              mc_addr  <= st_addr;
              mc_len   <= st_len;
              mc_wdata <= st_data;
            end
            default: begin
              state    <= IDLE;
              mc_valid <= 1'b0;
            end
          endcase
        end
        BUSY: begin
          if (mc_done) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            mc_valid <= 1'b0;
            mc_we    <= 1'b0;
            mc_addr  <= 32'd0;
            mc_len   <= 3'd0;
            mc_wdata <= 32'd0;
            // A flush arriving with mc_done still swallows a read's result.
            case (owner)
              OWN_ST: st_done <= 1'b1;
              OWN_LD: begin
                if (!clear) begin
                  ld_done <= 1'b1;
                  rdata   <= mc_rdata;
                end
              end
              OWN_IF: begin
                if (!clear) begin
                  if_done <= 1'b1;
                  rdata   <= mc_rdata;
                end
              end
              default: ;
            endcase
          end else if (clear && (owner == OWN_IF || owner == OWN_LD)) begin
            // The command is still in flight; wait it out silently.
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mc_done) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            mc_valid <= 1'b0;
            mc_we    <= 1'b0;
            mc_addr  <= 32'd0;
            mc_len   <= 3'd0;
            mc_wdata <= 32'd0;
          end
        end
        default: begin
          state    <= IDLE;
          owner    <= OWN_NONE;
          mc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb. Inputs change and outputs are sampled on the
// falling clock edge, half a cycle away from the rising edge the DUT uses.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_len;
  logic        st_req;
  logic [31:0] st_addr;
  logic [2:0]  st_len;
  logic [31:0] st_data;
  logic        if_done;
  logic        ld_done;
  logic        st_done;
  logic [31:0] rdata;
  logic        mc_valid;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;
  logic [1:0]  state_dbg;

  int tests_run;
  int tests_failed;

  mem_arb #(.STARVE_LIMIT(3'd4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (clear),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_len   (ld_len),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_len   (st_len),
    .st_data  (st_data),
    .if_done  (if_done),
    .ld_done  (ld_done),
    .st_done  (st_done),
    .rdata    (rdata),
    .mc_valid (mc_valid),
    .mc_we    (mc_we),
    .mc_addr  (mc_addr),
    .mc_len   (mc_len),
    .mc_wdata (mc_wdata),
    .mc_done  (mc_done),
    .mc_rdata (mc_rdata),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mc_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pulse mc_done for one cycle; returns at the negedge where done is visible.
  task automatic complete(input logic [31:0] rd);
    mc_done  = 1'b1;
    mc_rdata = rd;
    @(negedge clk);
    mc_done  = 1'b0;
    mc_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_addr = '0; ld_len = '0;
    st_req = 1'b0; st_addr = '0; st_len = '0; st_data = '0;
    mc_done = 1'b0; mc_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({if_done, ld_done, st_done, rdata, mc_valid, mc_we, mc_addr, mc_len, mc_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b done=%b%b%b rdata=%h, required all 0",
               mc_valid, if_done, ld_done, st_done, rdata);
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required 0", state_dbg);
    end
  endtask

  task automatic test_single_fetch();
    bit ok;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    @(negedge clk);
    tests_run++;
    if ({mc_valid, mc_we, mc_len, mc_addr} !== {1'b1, 1'b0, 3'd4, 32'h0000_1000}) begin
      tests_failed++;
      $display("FAIL fetch_cmd: got valid=%b we=%b len=%0d addr=%h, required 1 0 4 00001000",
               mc_valid, mc_we, mc_len, mc_addr);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!mc_valid || mc_addr !== 32'h0000_1000 || if_done) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fetch_hold: command not stable while BUSY (valid=%b addr=%h), required stable", mc_valid, mc_addr);
    end
    complete(32'hDEAD_BEEF);
    if_req = 1'b0;
    tests_run++;
    if ({if_done, ld_done, st_done, rdata, mc_valid} !== {3'b100, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL fetch_done: got done=%b%b%b rdata=%h valid=%b, required 100 deadbeef 0",
               if_done, ld_done, st_done, rdata, mc_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({if_done, rdata, mc_valid} !== '0) begin
      tests_failed++;
      $display("FAIL fetch_after: got if_done=%b rdata=%h valid=%b, required 0 0 0", if_done, rdata, mc_valid);
    end
  endtask

  task automatic test_priority();
    bit ok;
    if_req = 1'b1; if_addr = 32'h0000_7000;
    ld_req = 1'b1; ld_addr = 32'h0000_8000; ld_len = 3'd2;
    st_req = 1'b1; st_addr = 32'h0000_9000; st_len = 3'd4; st_data = 32'h1122_3344;
    @(negedge clk);
    tests_run++;
    if ({mc_valid, mc_we, mc_addr, mc_len, mc_wdata} !== {1'b1, 1'b1, 32'h0000_9000, 3'd4, 32'h1122_3344}) begin
      tests_failed++;
      $display("FAIL prio_st: got we=%b addr=%h len=%0d wdata=%h, required 1 00009000 4 11223344",
               mc_we, mc_addr, mc_len, mc_wdata);
    end
    complete(32'h0BAD_0BAD);
    st_req = 1'b0;
    tests_run++;
    if ({if_done, ld_done, st_done, rdata} !== {3'b001, 32'd0}) begin
      tests_failed++;
      $display("FAIL prio_st_done: got done=%b%b%b rdata=%h, required 001 0", if_done, ld_done, st_done, rdata);
    end
    wait_valid(ok);
    tests_run++;
    if (!ok || {mc_we, mc_addr, mc_len} !== {1'b0, 32'h0000_8000, 3'd2}) begin
      tests_failed++;
      $display("FAIL prio_ld: got ok=%b we=%b addr=%h len=%0d, required 1 0 00008000 2", ok, mc_we, mc_addr, mc_len);
    end
    complete(32'hCAFE_0002);
    ld_req = 1'b0;
    tests_run++;
    if ({if_done, ld_done, st_done, rdata} !== {3'b010, 32'hCAFE_0002}) begin
      tests_failed++;
      $display("FAIL prio_ld_done: got done=%b%b%b rdata=%h, required 010 cafe0002", if_done, ld_done, st_done, rdata);
    end
    wait_valid(ok);
    tests_run++;
    if (!ok || {mc_we, mc_addr, mc_len} !== {1'b0, 32'h0000_7000, 3'd4}) begin
      tests_failed++;
      $display("FAIL prio_if: got ok=%b we=%b addr=%h len=%0d, required 1 0 00007000 4", ok, mc_we, mc_addr, mc_len);
    end
    complete(32'h0000_0055);
    if_req = 1'b0;
    tests_run++;
    if ({if_done, rdata} !== {1'b1, 32'h0000_0055}) begin
      tests_failed++;
      $display("FAIL prio_if_done: got if_done=%b rdata=%h, required 1 00000055", if_done, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_idle();
    bit ok;
    if_req = 1'b1; if_addr = 32'h0000_A000;
    ld_req = 1'b1; ld_addr = 32'h0000_B000; ld_len = 3'd4;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests_run++;
    if (mc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_idle_block: got mc_valid=%b, required 0", mc_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({mc_valid, mc_addr} !== {1'b1, 32'h0000_B000}) begin
      tests_failed++;
      $display("FAIL clear_idle_next: got valid=%b addr=%h, required 1 0000b000", mc_valid, mc_addr);
    end
    if_req = 1'b0;
    complete(32'h0000_0001);
    ld_req = 1'b0;
    @(negedge clk);
    st_req = 1'b1; st_addr = 32'h0000_C000; st_len = 3'd2; st_data = 32'h0000_1234;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests_run++;
    if ({mc_valid, mc_we, mc_addr} !== {1'b1, 1'b1, 32'h0000_C000}) begin
      tests_failed++;
      $display("FAIL clear_idle_store: got valid=%b we=%b addr=%h, required 1 1 0000c000", mc_valid, mc_we, mc_addr);
    end
    wait_valid(ok);
    complete(32'd0);
    st_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit ok;
    int loads;
    bit got_if;
    loads = 0;
    got_if = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    ld_req = 1'b1; ld_addr = 32'h0000_3000; ld_len = 3'd1;
    for (int g = 0; g < 6 && !got_if; g++) begin
      wait_valid(ok);
      if (!ok) begin
        tests_run++;
        tests_failed++;
        $display("FAIL starve_wait: no grant within 20 cycles, required a grant");
        break;
      end
      if (mc_addr == 32'h0000_2000) begin
        got_if = 1'b1;
      end else begin
        loads++;
        complete(32'h0000_0100 + 32'(loads));
        if (loads == 6) ld_req = 1'b0;
      end
    end
`ifdef ARB_FAIR_EN
    tests_run++;
    if (!got_if || loads != 4) begin
      tests_failed++;
      $display("FAIL starve_fair: got fetch=%b after %0d loads, required fetch after 4 loads", got_if, loads);
    end
`else
    tests_run++;
    if (got_if || loads != 6) begin
      tests_failed++;
      $display("FAIL starve_strict: got fetch=%b after %0d loads, required no fetch in 6 load grants", got_if, loads);
    end
    wait_valid(ok);
`endif
    tests_run++;
    if ({mc_valid, mc_addr, mc_len} !== {1'b1, 32'h0000_2000, 3'd4}) begin
      tests_failed++;
      $display("FAIL starve_fetch: got valid=%b addr=%h len=%0d, required 1 00002000 4", mc_valid, mc_addr, mc_len);
    end
    complete(32'h0000_F00D);
    if_req = 1'b0;
    ld_req = 1'b0;
    tests_run++;
    if ({if_done, ld_done, rdata} !== {2'b10, 32'h0000_F00D}) begin
      tests_failed++;
      $display("FAIL starve_fetch_done: got if_done=%b ld_done=%b rdata=%h, required 1 0 0000f00d", if_done, ld_done, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_fetch();
    if_req = 1'b1; if_addr = 32'h0000_D000;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    tests_run++;
    if ({state_dbg, mc_valid, mc_addr} !== {2'd2, 1'b1, 32'h0000_D000}) begin
      tests_failed++;
      $display("FAIL flush_discard: got state=%0d valid=%b addr=%h, required 2 1 0000d000", state_dbg, mc_valid, mc_addr);
    end
    @(negedge clk);
    tests_run++;
    if (mc_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_hold: got mc_valid=%b, required 1", mc_valid);
    end
    complete(32'h0000_0BAD);
    tests_run++;
    if ({if_done, ld_done, st_done, rdata, mc_valid, state_dbg} !== '0) begin
      tests_failed++;
      $display("FAIL flush_end: got done=%b%b%b rdata=%h valid=%b state=%0d, required all 0",
               if_done, ld_done, st_done, rdata, mc_valid, state_dbg);
    end
    @(negedge clk);
    tests_run++;
    if (if_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_late: got if_done=%b, required 0", if_done);
    end
  endtask

  task automatic test_store_flush();
    int pulses;
    st_req = 1'b1; st_addr = 32'h0000_E000; st_len = 3'd1; st_data = 32'h0000_00A5;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests_run++;
    if ({state_dbg, mc_valid, mc_we} !== {2'd1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL st_flush_busy: got state=%0d valid=%b we=%b, required 1 1 1", state_dbg, mc_valid, mc_we);
    end
    complete(32'd0);
    st_req = 1'b0;
    pulses = int'(st_done);
    @(negedge clk);
    pulses += int'(st_done);
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL st_flush_done: got %0d st_done pulses, required 1", pulses);
    end
  endtask

  task automatic test_rdy_freeze();
    bit ok;
    ld_req = 1'b1; ld_addr = 32'h0000_5000; ld_len = 3'd1;
    @(negedge clk);
    rdy = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({mc_valid, mc_addr, mc_len, state_dbg} !== {1'b1, 32'h0000_5000, 3'd1, 2'd1}) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rdy_busy_hold: got valid=%b addr=%h state=%0d, required 1 00005000 1", mc_valid, mc_addr, state_dbg);
    end
    rdy = 1'b1;
    complete(32'h0000_00AB);
    ld_req = 1'b0;
    rdy = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({ld_done, rdata} !== {1'b1, 32'h0000_00AB}) ok = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rdy_done_hold: got ld_done=%b rdata=%h, required 1 000000ab while rdy low", ld_done, rdata);
    end
    rdy = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({ld_done, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL rdy_done_release: got ld_done=%b rdata=%h, required 0 0", ld_done, rdata);
    end
  endtask

  task automatic test_reset_mid_busy();
    if_req = 1'b1; if_addr = 32'h0000_6000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; rdy = 1'b0; if_req = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1; mc_done = 1'b0; mc_rdata = '0;
    tests_run++;
    if ({if_done, ld_done, st_done, rdata, mc_valid, mc_we, mc_addr, mc_len, mc_wdata, state_dbg} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_busy: got valid=%b addr=%h done=%b%b%b rdata=%h state=%0d, required all 0",
               mc_valid, mc_addr, if_done, ld_done, st_done, rdata, state_dbg);
    end
    @(negedge clk);
    tests_run++;
    if ({if_done, ld_done, st_done, mc_valid} !== '0) begin
      tests_failed++;
      $display("FAIL rst_after: got done=%b%b%b valid=%b, required 0", if_done, ld_done, st_done, mc_valid);
    end
  endtask

  // Test sequence and final report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_priority();
    test_clear_idle();
    test_starvation();
    test_flush_fetch();
    test_store_flush();
    test_rdy_freeze();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 3'd4: consecutive non-fetch grants tolerated while fetch waits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 clear  input  1  misprediction flush; drops fetch and load traffic.
REQ-006 if_req, if_addr  input  1, 32  fetch request; word read (4 bytes).
REQ-007 ld_req, ld_addr, ld_len  input  1, 32, 3  load request; ld_len is 1, 2 or 4.
REQ-008 st_req, st_addr, st_len, st_data  input  1, 32, 3, 32  store request.
REQ-009 if_done, ld_done, st_done  output  1 each  one-cycle completion pulses.
REQ-010 rdata  output  32  read data, valid in the if_done or ld_done cycle.
REQ-011 mc_valid, mc_we, mc_addr, mc_len, mc_wdata  output  1, 1, 32, 3, 32  command to the byte-serial memory controller.
REQ-012 mc_done, mc_rdata  input  1, 32  controller completion pulse and read data.

Function
REQ-013 Requester protocol: req held high with stable payload until its done pulse; the done pulse lasts exactly one cycle.
REQ-014 FSM states: IDLE, BUSY, DISCARD; owner register holds IF, LD or ST.
REQ-015 IDLE grant priority is st > ld > if, overridden by REQ-020 when compiled in.
REQ-016 On grant in cycle N: mc_valid, mc_we, mc_addr, mc_len and mc_wdata are registered and visible in N+1; state becomes BUSY.
REQ-017 Fetch grant drives mc_len=4 and mc_we=0; store grant drives mc_we=1 and mc_wdata=st_data.
REQ-018 mc_valid and the command fields stay stable through BUSY until mc_done; mc_valid drops the cycle after mc_done.
REQ-019 mc_done in BUSY in cycle M: owner done pulse and rdata (mc_rdata for reads, 0 for stores) appear in M+1; state returns to IDLE in M+1; the next grant may be decided in M+1.
REQ-020 While if_req waits ungranted, starve_cnt increments on each ld/st grant; when starve_cnt == STARVE_LIMIT, the next grant goes to fetch; starve_cnt clears on any fetch grant or when if_req is low.
REQ-021 clear in IDLE: if_req and ld_req are ignored that cycle; a store may still be granted.
REQ-022 clear in BUSY with owner IF or LD: state becomes DISCARD; mc_valid is held until mc_done, then state returns to IDLE with no done pulse.
REQ-023 clear has no effect on a store owner; the store completes normally.
REQ-024 clear in the same cycle as mc_done with owner IF or LD: the done pulse is suppressed.
REQ-025 An in-flight command is never aborted; the controller always sees mc_done before the next mc_valid.
REQ-026 At most one done pulse per cycle; rdata is 0 whenever no read done pulse is asserted.
REQ-027 rdy low: FSM, counters and outputs hold; a done pulse asserted when rdy fell stays asserted until rdy returns.

Reset
REQ-028 rst high at a clock edge: state=IDLE, owner=none, starve_cnt=0, and all outputs 0.
REQ-029 Reset mid-transaction abandons the command with no done pulse; rst takes precedence over rdy.

Configuration
REQ-030 Macro ARB_FAIR_EN defined: starvation counter and REQ-020 override are compiled in.
REQ-031 Macro ARB_FAIR_EN undefined: no counter logic; strict st > ld > if priority; ports unchanged.

Verification
REQ-032 Single fetch: if_req=1, if_addr=0x1000, mc_done after 5 cycles with mc_rdata=0xDEADBEEF -> mc_len=4, mc_we=0, if_done pulse with rdata=0xDEADBEEF the cycle after mc_done.
REQ-033 Simultaneous requests: if_req, ld_req and st_req (st_data=0x11223344, st_len=4) all high -> order ST, LD, IF; mc_wdata=0x11223344 on the ST command.
REQ-034 Starvation (ARB_FAIR_EN, STARVE_LIMIT=4): if_req held while ld_req stays high continuously -> fetch granted after exactly 4 load grants; without the macro, fetch is never granted while ld_req is high.
REQ-035 Flush: clear pulses 2 cycles into an IF transaction -> mc_valid held until mc_done, no if_done pulse, FSM back in IDLE.
REQ-036 Store under flush: clear during an ST transaction -> st_done still pulses once.
REQ-037 rdy low for 3 cycles mid-BUSY, and rst mid-BUSY -> outputs frozen during rdy low; after rst, all outputs 0 and no done pulse.
